// File: rtl/cntr_cla_n.sv
// Loadable up/down counter whose next value comes from a ripple of cla4 adder stages.
// Supports hold, wrap or saturate at the limits, a terminal-count pulse and a visible FSM state.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s  = p ^ c[3:0];
    assign co = c[4];
endmodule

module cntr_cla_n #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       o_state,
    output logic             tc
);
    localparam int NSTG = WIDTH / 4;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [NSTG:0]    carry;
    logic             limit;

    // Decrement is an add of all-ones, so one adder serves both directions.
    assign addend   = inc ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NSTG; i++) begin : g_stage
        cla4 u_cla4 (
            .a  (d_out[4*i +: 4]),
            .b  (addend[4*i +: 4]),
            .ci (carry[i]),
            .s  (sum[4*i +: 4]),
            .co (carry[i+1])
        );
    end

    // Carry-out means overflow when counting up, but no-borrow when counting down.
    assign limit = inc ? carry[NSTG] : ~carry[NSTG];

    always_comb begin
        state_d = state_q;
        cnt_d   = d_out;
        tc_d    = 1'b0;
        if (load) begin
            state_d = LOAD;
            cnt_d   = d_in;
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            if (inc) begin
                state_d = (state_q == INC) ? INC2 : INC;
            end else begin
                state_d = (state_q == DEC) ? DEC2 : DEC;
            end
            tc_d  = limit;
            cnt_d = (SAT && limit) ? d_out : sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            d_out   <= '0;
            tc      <= 1'b0;
        end else begin
            state_q <= state_d;
            d_out   <= cnt_d;
            tc      <= tc_d;
        end
    end

    assign o_state = state_q;
endmodule

// File: tb/tb_cntr_cla_n.sv
// Bench for cntr_cla_n: wrap and saturate 8-bit instances plus a 16-bit wrap instance,
// driven from directed vectors and checked through an expected-value queue.

module tb_cntr_cla_n;
    logic        clk;
    logic        reset_n;
    logic        en;
    logic        load;
    logic        inc;
    logic [15:0] d_in;

    logic [7:0]  d_out_w;
    logic [2:0]  st_w;
    logic        tc_w;
    logic [7:0]  d_out_s;
    logic [2:0]  st_s;
    logic        tc_s;
    logic [15:0] d_out_l;
    logic [2:0]  st_l;
    logic        tc_l;

    int n_cmp = 0;
    int n_err = 0;

    // Entry layout: {dut id[1:0], d_out[15:0], state[2:0], tc}
    logic [21:0] exp_q[$];

    localparam logic [2:0] S_IDLE = 3'b000, S_LOAD = 3'b001, S_INC = 3'b010,
                           S_INC2 = 3'b011, S_DEC = 3'b100, S_DEC2 = 3'b101;

    cntr_cla_n #(.WIDTH(8), .SAT(1'b0)) u_wrap8 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .inc(inc),
        .d_in(d_in[7:0]), .d_out(d_out_w), .o_state(st_w), .tc(tc_w)
    );

    cntr_cla_n #(.WIDTH(8), .SAT(1'b1)) u_sat8 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .inc(inc),
        .d_in(d_in[7:0]), .d_out(d_out_s), .o_state(st_s), .tc(tc_s)
    );

    cntr_cla_n #(.WIDTH(16), .SAT(1'b0)) u_wrap16 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .inc(inc),
        .d_in(d_in), .d_out(d_out_l), .o_state(st_l), .tc(tc_l)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: one input vector per cycle, expectation queued for the following edge
    task automatic step(input int id, input logic ld, input logic e, input logic i,
                        input logic [15:0] din, input logic [15:0] xd,
                        input logic [2:0] xs, input logic xt);
        logic [1:0] idb;
        @(negedge clk);
        load = ld;
        en   = e;
        inc  = i;
        d_in = din;
        idb  = id[1:0];
        exp_q.push_back({idb, xd, xs, xt});
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        inc  = 1'b0;
        d_in = '0;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_wrap8_d"},  {24'd0, d_out_w}, 32'd0);
        check({tag, "_wrap8_st"}, {29'd0, st_w},    32'd0);
        check({tag, "_wrap8_tc"}, {31'd0, tc_w},    32'd0);
        check({tag, "_sat8_d"},   {24'd0, d_out_s}, 32'd0);
        check({tag, "_wrap16_d"}, {16'd0, d_out_l}, 32'd0);
        check({tag, "_wrap16_st"},{29'd0, st_l},    32'd0);
    endtask

    // Monitor / scoreboard: outputs are sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        logic [21:0] e;
        logic [15:0] act_d;
        logic [2:0]  act_s;
        logic        act_t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e[21:20])
                2'd0:    begin act_d = {8'd0, d_out_w}; act_s = st_w; act_t = tc_w; end
                2'd1:    begin act_d = {8'd0, d_out_s}; act_s = st_s; act_t = tc_s; end
                default: begin act_d = d_out_l;         act_s = st_l; act_t = tc_l; end
            endcase
            check($sformatf("dut%0d_d_out", e[21:20]), {16'd0, act_d}, {16'd0, e[19:4]});
            check($sformatf("dut%0d_state", e[21:20]), {29'd0, act_s}, {29'd0, e[3:1]});
            check($sformatf("dut%0d_tc", e[21:20]),    {31'd0, act_t}, {31'd0, e[0]});
        end
    end

    initial begin
        reset_n = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        inc  = 1'b0;
        d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_clear("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Async reset mid-count at 0x37
        step(0, 1'b1, 1'b0, 1'b0, 16'h0036, 16'h0036, S_LOAD, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0037, S_INC,  1'b0);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_clear("midrst");
        @(posedge clk);
        #1;
        check_all_clear("rsthold");
        @(negedge clk);
        reset_n = 1'b1;
        // First edge after release evaluates from IDLE
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, S_INC,  1'b0);

        // Wrap up through all-ones
        step(0, 1'b1, 1'b0, 1'b0, 16'h00FE, 16'h00FE, S_LOAD, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, S_INC,  1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, S_INC2, 1'b1);
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, S_INC,  1'b0);

        // Wrap down through zero, then direction change from DEC2
        step(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, S_LOAD, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00FF, S_DEC,  1'b1);
        step(0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00FE, S_DEC2, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, S_INC,  1'b0);

        // Saturate at zero
        step(1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, S_LOAD, 1'b0);
        step(1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, S_DEC,  1'b0);
        step(1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, S_DEC2, 1'b1);
        step(1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, S_DEC,  1'b1);

        // Saturate at all-ones; load of all-ones never raises tc
        step(1, 1'b1, 1'b0, 1'b0, 16'h00FE, 16'h00FE, S_LOAD, 1'b0);
        step(1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, S_INC,  1'b0);
        step(1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, S_INC2, 1'b1);
        step(1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, S_INC,  1'b1);
        step(1, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h00FF, S_LOAD, 1'b0);

        // Hold for 4 cycles at 0x10
        step(0, 1'b1, 1'b0, 1'b0, 16'h000F, 16'h000F, S_LOAD, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, S_INC,  1'b0);
        for (int k = 0; k < 4; k++)
            step(0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, S_IDLE, 1'b0);

        // Load beats enable
        step(0, 1'b1, 1'b1, 1'b1, 16'h00A5, 16'h00A5, S_LOAD, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, 16'h005A, 16'h005A, S_LOAD, 1'b0);

        // 16-bit: carry and borrow across a cla4 stage boundary, full wrap
        step(2, 1'b1, 1'b0, 1'b0, 16'h0FFF, 16'h0FFF, S_LOAD, 1'b0);
        step(2, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, S_INC,  1'b0);
        step(2, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0FFF, S_DEC,  1'b0);
        step(2, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, S_LOAD, 1'b0);
        step(2, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, S_INC,  1'b1);
        step(2, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, S_DEC,  1'b1);

        idle_inputs();
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
